// File: rtl/wave_osc_multi.sv
`timescale 1ns / 1ps
// wave_osc_multi -- time-multiplexed multi-channel waveform oscillator.
// CH channels share one datapath. Each EN-high cycle serves one channel slot,
// and that slot's sample leaves a two-stage pipeline two cycles later.
// Optional feature: define OSC_HARD_SYNC_EN to add the SYNC hard-sync input.
module wave_osc_multi #(
   parameter  int CH  = 4,
   parameter  int W   = 16,
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic           EN,
   input  logic           CFG_WE,
   input  logic [CHW-1:0] CFG_CH,
   input  logic [1:0]     CFG_FORM,
   input  logic [31:0]    CFG_FREQ,
   input  logic [W-1:0]   CFG_DUTY,
`ifdef OSC_HARD_SYNC_EN
   input  logic [CH-1:0]  SYNC,
`endif
   output logic           OUT_VALID,
   output logic [CHW-1:0] OUT_CH,
   output logic [W-1:0]   OUT_SIG,
   output logic           FRAME
);

   typedef enum logic [1:0] {
      FORM_SAW      = 2'b00,
      FORM_SQUARE   = 2'b01,
      FORM_TRIANGLE = 2'b10,
      FORM_NOISE    = 2'b11
   } form_e;

   // Galois mask for x^32 + x^22 + x^2 + x + 1, shifting towards bit 0.
   localparam logic [31:0]    LFSR_TAPS = 32'h8020_0003;
   localparam logic [31:0]    LFSR_SEED = 32'h0000_0001;
   localparam logic [W-1:0]   MID_SCALE = {1'b1, {(W-1){1'b0}}};
   localparam logic [CHW-1:0] LAST_SLOT = CHW'(CH - 1);

   // Per-channel state and configuration
   logic [31:0]    phase [CH];
   logic [W-1:0]   hold  [CH];
   logic [31:0]    freq  [CH];
   form_e          form  [CH];
   logic [W-1:0]   duty  [CH];
   logic [31:0]    lfsr;
   logic [CHW-1:0] slot;

   // Slot arithmetic
   logic [CHW-1:0] slot_next;
   logic [31:0]    lfsr_next;
   logic [32:0]    phase_sum;
   logic           sync_hit;
   logic           carry;
   logic [W-1:0]   slot_p;
   logic           cfg_ok;

   // Pipeline stage 1
   logic           s1_valid;
   logic [CHW-1:0] s1_ch;
   logic [W-1:0]   s1_p;
   form_e          s1_form;
   logic [W-1:0]   s1_duty;
   logic [W-1:0]   s1_hold;
   logic [W-1:0]   p_dbl;
   logic [W-1:0]   wave;

`ifdef OSC_HARD_SYNC_EN
   logic [CH-1:0]  pending;
   logic [CH-1:0]  slot_hit;
`endif

   // Per-slot next-state arithmetic: phase add with carry, sync override, LFSR step.
   always_comb begin
      sync_hit  = 1'b0;
`ifdef OSC_HARD_SYNC_EN
      sync_hit  = pending[slot];
`endif
      phase_sum = {1'b0, phase[slot]} + {1'b0, freq[slot]};
      carry     = phase_sum[32] & ~sync_hit;
      slot_p    = sync_hit ? '0 : phase[slot][31 -: W];
      lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
      slot_next = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
   end

   // Oscillator state: advances only on EN-high cycles, one channel per cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      // NOTE: clocked state uses <= so every register samples pre-edge values.
      if (!RST_N) begin
         // NOTE: the per-channel arrays are real state with defined reset values,
         // so they are cleared by loop here rather than inferred as RAM.
         for (int i = 0; i < CH; i++) begin
            phase[i] <= '0;
            hold[i]  <= MID_SCALE;
         end
         lfsr <= LFSR_SEED;
         slot <= '0;
      end else if (EN) begin
         phase[slot] <= sync_hit ? freq[slot] : phase_sum[31:0];
         if (carry) hold[slot] <= lfsr[W-1:0];
         lfsr <= lfsr_next;
         slot <= slot_next;
      end
   end

`ifdef OSC_HARD_SYNC_EN
   // One-hot marker of the channel served this cycle.
   always_comb begin
      slot_hit       = '0;
      slot_hit[slot] = EN;
   end

   // Hard-sync requests: a pulse arms the flag, the channel's next slot consumes it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) pending <= '0;
      else        pending <= (pending & ~slot_hit) | SYNC;
   end
`endif

   assign cfg_ok = ({{(32-CHW){1'b0}}, CFG_CH} < 32'(CH));

   // Configuration registers: the slot reading a channel this cycle still sees old values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < CH; i++) begin
            freq[i] <= '0;
            form[i] <= FORM_SAW;
            duty[i] <= MID_SCALE;
         end
      end else if (CFG_WE && cfg_ok) begin
         freq[CFG_CH] <= CFG_FREQ;
         form[CFG_CH] <= form_e'(CFG_FORM);
         duty[CFG_CH] <= CFG_DUTY;
      end
   end

   // Stage 1: capture the slot's phase sample and the settings that shape it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_valid <= 1'b0;
         s1_ch    <= '0;
         s1_p     <= '0;
         s1_form  <= FORM_SAW;
         s1_duty  <= MID_SCALE;
         s1_hold  <= MID_SCALE;
      end else begin
         s1_valid <= EN;
         if (EN) begin
            s1_ch   <= slot;
            s1_p    <= slot_p;
            s1_form <= form[slot];
            s1_duty <= duty[slot];
            s1_hold <= hold[slot];
         end
      end
   end

   // Waveform shaping of the stage-1 sample.
   always_comb begin
      // NOTE: default first, so no path through the case leaves wave unassigned (no latch).
      wave  = s1_hold;
      p_dbl = {s1_p[W-2:0], 1'b0};
      case (s1_form)
         FORM_SAW:      wave = s1_p;
         FORM_SQUARE:   wave = (s1_p < s1_duty) ? '1 : '0;
         FORM_TRIANGLE: wave = s1_p[W-1] ? ~p_dbl : p_dbl;
         default:       wave = s1_hold;
      endcase
   end

   // Stage 2: register the shaped sample; hold the last one while nothing is in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OUT_VALID <= 1'b0;
         OUT_CH    <= '0;
         OUT_SIG   <= MID_SCALE;
         FRAME     <= 1'b0;
      end else begin
         OUT_VALID <= s1_valid;
         FRAME     <= s1_valid && (s1_ch == '0);
         if (s1_valid) begin
            OUT_CH  <= s1_ch;
            OUT_SIG <= wave;
         end
      end
   end

endmodule

// File: tb/tb_wave_osc_multi.sv
`timescale 1ns / 1ps
// tb_wave_osc_multi -- self-checking bench for wave_osc_multi at CH=4, W=16.
// A behavioural model computes each slot's sample from phase arithmetic and
// pushes it through a two-cycle delay; scenario tasks compare every cycle.
module tb_wave_osc_multi;

   localparam int CH  = 4;
   localparam int W   = 16;
   localparam int CHW = 2;

   logic           CLK      = 1'b0;
   logic           RST_N    = 1'b1;
   logic           EN       = 1'b0;
   logic           CFG_WE   = 1'b0;
   logic [CHW-1:0] CFG_CH   = '0;
   logic [1:0]     CFG_FORM = '0;
   logic [31:0]    CFG_FREQ = '0;
   logic [W-1:0]   CFG_DUTY = '0;
`ifdef OSC_HARD_SYNC_EN
   logic [CH-1:0]  SYNC     = '0;
`endif
   logic           OUT_VALID;
   logic [CHW-1:0] OUT_CH;
   logic [W-1:0]   OUT_SIG;
   logic           FRAME;

   int checks = 0;
   int errors = 0;

   wave_osc_multi #(.CH(CH), .W(W)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .EN       (EN),
      .CFG_WE   (CFG_WE),
      .CFG_CH   (CFG_CH),
      .CFG_FORM (CFG_FORM),
      .CFG_FREQ (CFG_FREQ),
      .CFG_DUTY (CFG_DUTY),
`ifdef OSC_HARD_SYNC_EN
      .SYNC     (SYNC),
`endif
      .OUT_VALID(OUT_VALID),
      .OUT_CH   (OUT_CH),
      .OUT_SIG  (OUT_SIG),
      .FRAME    (FRAME)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   logic [31:0]    m_phase [CH];
   logic [31:0]    m_freq  [CH];
   logic [1:0]     m_form  [CH];
   logic [W-1:0]   m_duty  [CH];
   logic [W-1:0]   m_hold  [CH];
   bit             m_pend  [CH];
   logic [31:0]    m_lfsr;
   int             m_slot;
   bit             s1_valid;
   int             s1_ch;
   logic [W-1:0]   s1_sig;
   bit             m_valid;
   bit             m_frame;
   logic [CHW-1:0] m_ch;
   logic [W-1:0]   m_sig;

   function automatic logic [31:0] lfsr_advance(input logic [31:0] v);
      if (v[0]) return (v >> 1) ^ 32'h8020_0003;
      return v >> 1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < CH; i++) begin
         m_phase[i] = '0;
         m_freq[i]  = '0;
         m_form[i]  = 2'b00;
         m_duty[i]  = 16'h8000;
         m_hold[i]  = 16'h8000;
         m_pend[i]  = 1'b0;
      end
      m_lfsr   = 32'h1;
      m_slot   = 0;
      s1_valid = 1'b0;
      s1_ch    = 0;
      s1_sig   = '0;
      m_valid  = 1'b0;
      m_frame  = 1'b0;
      m_ch     = '0;
      m_sig    = 16'h8000;
   endfunction

   // One clock cycle of the specified behaviour, using the inputs currently driven.
   function automatic void model_cycle();
      bit           nv;
      int           nch;
      logic [W-1:0] nsig;
      int unsigned  p;
      logic [63:0]  sum;
      int           s;
      nv   = 1'b0;
      nch  = 0;
      nsig = '0;
      // The sample computed last cycle reaches the outputs now.
      m_valid = s1_valid;
      m_frame = s1_valid && (s1_ch == 0);
      if (s1_valid) begin
         m_ch  = CHW'(s1_ch);
         m_sig = s1_sig;
      end
      if (EN) begin
         s = m_slot;
         p = m_pend[s] ? 0 : (m_phase[s] >> (32 - W));
         case (m_form[s])
            2'b00: nsig = W'(p);
            2'b01: nsig = (p < m_duty[s]) ? {W{1'b1}} : '0;
            2'b10: nsig = (p < (1 << (W - 1))) ? W'(2 * p) : W'(((1 << (W + 1)) - 1) - 2 * p);
            default: nsig = m_hold[s];
         endcase
         if (m_pend[s]) begin
            m_phase[s] = m_freq[s];
            m_pend[s]  = 1'b0;
         end else begin
            sum = 64'(m_phase[s]) + 64'(m_freq[s]);
            if (sum > 64'hFFFF_FFFF) m_hold[s] = m_lfsr[W-1:0];
            m_phase[s] = sum[31:0];
         end
         m_lfsr = lfsr_advance(m_lfsr);
         m_slot = (s + 1) % CH;
         nv     = 1'b1;
         nch    = s;
      end
`ifdef OSC_HARD_SYNC_EN
      for (int c = 0; c < CH; c++) if (SYNC[c]) m_pend[c] = 1'b1;
`endif
      if (CFG_WE && int'(CFG_CH) < CH) begin
         m_freq[CFG_CH] = CFG_FREQ;
         m_form[CFG_CH] = CFG_FORM;
         m_duty[CFG_CH] = CFG_DUTY;
      end
      s1_valid = nv;
      s1_ch    = nch;
      s1_sig   = nsig;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      model_cycle();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N  = 1'b0;
      EN     = 1'b0;
      CFG_WE = 1'b0;
`ifdef OSC_HARD_SYNC_EN
      SYNC   = '0;
`endif
      #1;
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic cfg_write(input int ch, input logic [1:0] fm, input logic [31:0] fq,
                            input logic [W-1:0] dt);
      CFG_WE   = 1'b1;
      CFG_CH   = CHW'(ch);
      CFG_FORM = fm;
      CFG_FREQ = fq;
      CFG_DUTY = dt;
      tick();
      CFG_WE   = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      EN    = 1'b0;
      #1;
      model_reset();
      if (OUT_SIG !== 16'h8000) begin
         errors++; $display("FAIL reset_sig: got %h want 8000", OUT_SIG);
      end
      checks++;
      if (OUT_VALID !== 1'b0 || OUT_CH !== 2'd0 || FRAME !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: got v=%b ch=%0d frame=%b want v=0 ch=0 frame=0",
                  OUT_VALID, OUT_CH, FRAME);
      end
      checks++;
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      EN    = 1'b1;
      tick();
      if (OUT_VALID !== 1'b0) begin
         errors++; $display("FAIL reset_latency: got valid=%b want 0 one cycle after EN", OUT_VALID);
      end
      checks++;
      for (int i = 0; i < 8; i++) begin
         bit want_fr;
         tick();
         want_fr = (i % 4 == 0);
         if (OUT_VALID !== 1'b1 || OUT_CH !== CHW'(i % 4) || FRAME !== want_fr || OUT_SIG !== 16'h0000) begin
            errors++;
            $display("FAIL reset_seq[%0d]: got v=%b ch=%0d frame=%b sig=%h want v=1 ch=%0d frame=%b sig=0000",
                     i, OUT_VALID, OUT_CH, FRAME, OUT_SIG, i % 4, want_fr);
         end
         checks++;
      end
      EN = 1'b0;
   endtask

   task automatic test_waveforms();
      logic [W-1:0] exp_tab [3][5];
      string        names [3];
      exp_tab = '{'{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000},
                  '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF},
                  '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000}};
      names   = '{"saw", "square", "triangle"};
      for (int f = 0; f < 3; f++) begin
         int got;
         do_reset();
         cfg_write(1, 2'(f), 32'h4000_0000, 16'h4000);
         EN  = 1'b1;
         got = 0;
         for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            tick();
            if (OUT_VALID !== m_valid || OUT_CH !== m_ch || OUT_SIG !== m_sig || FRAME !== m_frame) begin
               errors++;
               $display("FAIL wave_model t=%0t: got v=%b ch=%0d sig=%h fr=%b want v=%b ch=%0d sig=%h fr=%b",
                        $time, OUT_VALID, OUT_CH, OUT_SIG, FRAME, m_valid, m_ch, m_sig, m_frame);
            end
            checks++;
            if (OUT_VALID === 1'b1 && OUT_CH === 2'd1) begin
               if (OUT_SIG !== exp_tab[f][got]) begin
                  errors++;
                  $display("FAIL wave_%s[%0d]: got %h want %h", names[f], got, OUT_SIG, exp_tab[f][got]);
               end
               checks++;
               got++;
            end
         end
         if (got < 5) begin
            errors++; $display("FAIL wave_%s_timeout: got %0d samples want 5", names[f], got);
            checks++;
         end
         EN = 1'b0;
      end
   endtask

   task automatic test_collision();
      logic [W-1:0] exp_c [3];
      int           got;
      exp_c = '{16'h0000, 16'h0000, 16'h4000};
      do_reset();
      EN = 1'b1;
      for (int n = 0; n < 10 && m_slot != 2; n++) tick();
      cfg_write(2, 2'b00, 32'h4000_0000, 16'h8000);
      got = 0;
      for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
         tick();
         if (OUT_VALID !== m_valid || OUT_CH !== m_ch || OUT_SIG !== m_sig || FRAME !== m_frame) begin
            errors++;
            $display("FAIL collide_model t=%0t: got v=%b ch=%0d sig=%h fr=%b want v=%b ch=%0d sig=%h fr=%b",
                     $time, OUT_VALID, OUT_CH, OUT_SIG, FRAME, m_valid, m_ch, m_sig, m_frame);
         end
         checks++;
         if (OUT_VALID === 1'b1 && OUT_CH === 2'd2) begin
            if (OUT_SIG !== exp_c[got]) begin
               errors++; $display("FAIL collide[%0d]: got %h want %h", got, OUT_SIG, exp_c[got]);
            end
            checks++;
            got++;
         end
      end
      if (got < 3) begin
         errors++; $display("FAIL collide_timeout: got %0d samples want 3", got);
         checks++;
      end
      EN = 1'b0;
   endtask

   task automatic test_pause();
      int           last_ch;
      int           first_ch;
      logic [W-1:0] held;
      do_reset();
      for (int c = 0; c < CH; c++)
         cfg_write(c, 2'($urandom_range(0, 3)), $urandom, 16'($urandom));
      EN = 1'b1;
      for (int n = 0; n < 14 && !(n >= 6 && m_slot == 2); n++) begin
         tick();
         if (OUT_VALID !== m_valid || OUT_CH !== m_ch || OUT_SIG !== m_sig || FRAME !== m_frame) begin
            errors++;
            $display("FAIL pause_model t=%0t: got v=%b ch=%0d sig=%h fr=%b want v=%b ch=%0d sig=%h fr=%b",
                     $time, OUT_VALID, OUT_CH, OUT_SIG, FRAME, m_valid, m_ch, m_sig, m_frame);
         end
         checks++;
      end
      EN      = 1'b0;
      last_ch = 0;
      held    = '0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) begin
            last_ch = int'(OUT_CH);
            held    = OUT_SIG;
            if (OUT_VALID !== 1'b1) begin
               errors++; $display("FAIL pause_drain: got valid=%b want 1", OUT_VALID);
            end
         end else if (OUT_VALID !== 1'b0 || OUT_SIG !== held) begin
            errors++;
            $display("FAIL pause_idle[%0d]: got valid=%b sig=%h want valid=0 sig=%h", k, OUT_VALID, OUT_SIG, held);
         end
         checks++;
         if (OUT_VALID !== m_valid || OUT_CH !== m_ch || OUT_SIG !== m_sig || FRAME !== m_frame) begin
            errors++;
            $display("FAIL pause_model t=%0t: got v=%b ch=%0d sig=%h fr=%b want v=%b ch=%0d sig=%h fr=%b",
                     $time, OUT_VALID, OUT_CH, OUT_SIG, FRAME, m_valid, m_ch, m_sig, m_frame);
         end
         checks++;
      end
      EN       = 1'b1;
      first_ch = -1;
      for (int n = 0; n < 12; n++) begin
         tick();
         if (OUT_VALID !== m_valid || OUT_CH !== m_ch || OUT_SIG !== m_sig || FRAME !== m_frame) begin
            errors++;
            $display("FAIL pause_model t=%0t: got v=%b ch=%0d sig=%h fr=%b want v=%b ch=%0d sig=%h fr=%b",
                     $time, OUT_VALID, OUT_CH, OUT_SIG, FRAME, m_valid, m_ch, m_sig, m_frame);
         end
         checks++;
         if (first_ch < 0 && OUT_VALID === 1'b1) first_ch = int'(OUT_CH);
      end
      if (first_ch != (last_ch + 1) % CH) begin
         errors++; $display("FAIL pause_resume_ch: got %0d want %0d", first_ch, (last_ch + 1) % CH);
      end
      checks++;
      EN = 1'b0;
   endtask

   task automatic test_noise();
      int           seen;
      int           changes;
      logic [W-1:0] prev;
      do_reset();
      cfg_write(3, 2'b11, 32'h8000_0000, 16'h0000);
      EN      = 1'b1;
      seen    = 0;
      changes = 0;
      prev    = '0;
      for (int n = 0; n < 80; n++) begin
         tick();
         if (OUT_VALID !== m_valid || OUT_CH !== m_ch || OUT_SIG !== m_sig || FRAME !== m_frame) begin
            errors++;
            $display("FAIL noise_model t=%0t: got v=%b ch=%0d sig=%h fr=%b want v=%b ch=%0d sig=%h fr=%b",
                     $time, OUT_VALID, OUT_CH, OUT_SIG, FRAME, m_valid, m_ch, m_sig, m_frame);
         end
         checks++;
         if (OUT_VALID === 1'b1 && OUT_CH === 2'd3) begin
            if (seen == 0) begin
               if (OUT_SIG !== 16'h8000) begin
                  errors++; $display("FAIL noise_first: got %h want 8000", OUT_SIG);
               end
               checks++;
            end else if (OUT_SIG !== prev) begin
               changes++;
            end
            prev = OUT_SIG;
            seen++;
         end
      end
      if (changes < 4) begin
         errors++; $display("FAIL noise_changes: got %0d changes want at least 4", changes);
      end
      checks++;
      EN = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         EN     = ($urandom_range(0, 3) != 0);
         CFG_WE = ($urandom_range(0, 3) == 0);
         if (CFG_WE) begin
            CFG_CH   = 2'($urandom_range(0, 3));
            CFG_FORM = 2'($urandom_range(0, 3));
            CFG_FREQ = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            CFG_DUTY = 16'($urandom);
         end
`ifdef OSC_HARD_SYNC_EN
         SYNC = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
`endif
         tick();
         if (OUT_VALID !== m_valid || OUT_CH !== m_ch || OUT_SIG !== m_sig || FRAME !== m_frame) begin
            errors++;
            $display("FAIL random_model t=%0t: got v=%b ch=%0d sig=%h fr=%b want v=%b ch=%0d sig=%h fr=%b",
                     $time, OUT_VALID, OUT_CH, OUT_SIG, FRAME, m_valid, m_ch, m_sig, m_frame);
         end
         checks++;
      end
      CFG_WE = 1'b0;
`ifdef OSC_HARD_SYNC_EN
      SYNC = '0;
`endif
      EN = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      cfg_write(0, 2'b00, 32'h1234_5678, 16'h8000);
      EN = 1'b1;
      repeat (7) tick();
      #2;
      RST_N = 1'b0;
      #1;
      model_reset();
      if (OUT_VALID !== 1'b0 || OUT_SIG !== 16'h8000 || OUT_CH !== 2'd0 || FRAME !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async: got v=%b sig=%h ch=%0d fr=%b want v=0 sig=8000 ch=0 fr=0",
                  OUT_VALID, OUT_SIG, OUT_CH, FRAME);
      end
      checks++;
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      if (OUT_VALID !== 1'b0) begin
         errors++; $display("FAIL midreset_flush: got valid=%b want 0", OUT_VALID);
      end
      checks++;
      tick();
      if (OUT_VALID !== 1'b1 || OUT_CH !== 2'd0 || OUT_SIG !== 16'h0000 || FRAME !== 1'b1) begin
         errors++;
         $display("FAIL midreset_first: got v=%b ch=%0d sig=%h fr=%b want v=1 ch=0 sig=0000 fr=1",
                  OUT_VALID, OUT_CH, OUT_SIG, FRAME);
      end
      checks++;
      EN = 1'b0;
   endtask

`ifdef OSC_HARD_SYNC_EN
   task automatic test_sync();
      logic [W-1:0] exp_s [2];
      bit           armed;
      int           got;
      exp_s = '{16'h0000, 16'h4000};
      do_reset();
      cfg_write(1, 2'b00, 32'h4000_0000, 16'h8000);
      EN    = 1'b1;
      armed = 1'b0;
      for (int n = 0; n < 40 && !armed; n++) begin
         tick();
         if (OUT_VALID === 1'b1 && OUT_CH === 2'd1 && OUT_SIG === 16'h8000) armed = 1'b1;
      end
      if (!armed) begin
         errors++; $display("FAIL sync_setup: got no ch1 sample 8000 want one");
         checks++;
      end
      SYNC = 4'b0010;
      tick();
      SYNC = '0;
      got  = 0;
      for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
         tick();
         if (OUT_VALID !== m_valid || OUT_CH !== m_ch || OUT_SIG !== m_sig || FRAME !== m_frame) begin
            errors++;
            $display("FAIL sync_model t=%0t: got v=%b ch=%0d sig=%h fr=%b want v=%b ch=%0d sig=%h fr=%b",
                     $time, OUT_VALID, OUT_CH, OUT_SIG, FRAME, m_valid, m_ch, m_sig, m_frame);
         end
         checks++;
         if (OUT_VALID === 1'b1 && OUT_CH === 2'd1) begin
            if (OUT_SIG !== exp_s[got]) begin
               errors++; $display("FAIL sync[%0d]: got %h want %h", got, OUT_SIG, exp_s[got]);
            end
            checks++;
            got++;
         end
      end
      if (got < 2) begin
         errors++; $display("FAIL sync_timeout: got %0d samples want 2", got);
         checks++;
      end
      EN = 1'b0;
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at time limit, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      test_reset();
      test_waveforms();
      test_collision();
      test_pause();
      test_noise();
`ifdef OSC_HARD_SYNC_EN
      test_sync();
`endif
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
